chip8_vga_pixel_fetch: RTL and testbench

//  Downstream consumer of the VGA timing generator. Maps beam position to the
//  64x32 monochrome CHIP-8 display (8x scaled by default, centred in 640x480), fetches display bytes

---
 rtl/chip8_vga_pixel_fetch.sv | 104 ++++++++++
 tb/tb_chip8_vga_pixel_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/chip8_vga_pixel_fetch.sv
// Maps VGA beam position onto a scaled, centred 64x32 CHIP-8 framebuffer and streams 12-bit RGB.
// Latency 2 (rgb/syncs); no backpressure, one pixel per clock; the RAM returns data one cycle after mem_rd.
module chip8_vga_pixel_fetch #(
  parameter int unsigned SCALE_SHIFT  = 3,
  parameter int unsigned X_OFFSET     = 64,
  parameter int unsigned Y_OFFSET     = 112,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] BORDER_COLOR = 12'h222
) (
  input  logic        clk,
  input  logic        res,
  input  logic [10:0] h_pos,
  input  logic [10:0] v_pos,
  input  logic        pixel_enable,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [11:0] rgb,
  output logic        h_sync,
  output logic        v_sync,
  output logic        frame_tick
);

  localparam logic [10:0] X_LO = 11'(X_OFFSET);
  localparam logic [10:0] X_HI = 11'(X_OFFSET + (64 << SCALE_SHIFT));
  localparam logic [10:0] Y_LO = 11'(Y_OFFSET);
  localparam logic [10:0] Y_HI = 11'(Y_OFFSET + (32 << SCALE_SHIFT));

  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [5:0]  w_col;
  logic [4:0]  w_row;
  logic        w_in_win;
  logic        w_sel;
  logic        w_unused;

  // Window test uses absolute compares so the wrapped dx/dy below X/Y_OFFSET can never alias in.
  assign w_dx     = h_pos - X_LO;
  assign w_dy     = v_pos - Y_LO;
  assign w_col    = w_dx[SCALE_SHIFT +: 6];
  assign w_row    = w_dy[SCALE_SHIFT +: 5];
  assign w_in_win = pixel_enable & (h_pos >= X_LO) & (h_pos < X_HI)
                  & (v_pos >= Y_LO) & (v_pos < Y_HI);
  assign w_unused = ^{w_dx, w_dy};

  // Stage 0 state
  logic       r_in_win1;
  logic       r_en1;
  logic [2:0] r_col1;
  logic       r_hs1;
  logic       r_vs1;
  // Stage 1 state, aligned with mem_data
  logic       r_in_win2;
  logic       r_en2;
  logic [2:0] r_col2;

  always_ff @(posedge clk) begin
    if (res) begin
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      r_in_win1  <= 1'b0;
      r_en1      <= 1'b0;
      r_col1     <= '0;
      r_hs1      <= 1'b0;
      r_vs1      <= 1'b0;
      r_in_win2  <= 1'b0;
      r_en2      <= 1'b0;
      r_col2     <= '0;
      h_sync     <= 1'b0;
      v_sync     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      mem_rd <= w_in_win;
      if (w_in_win) mem_addr <= {w_row, w_col[5:3]};
      r_in_win1  <= w_in_win;
      r_en1      <= pixel_enable;
      r_col1     <= w_col[2:0];
      r_hs1      <= h_sync_in;
      r_vs1      <= v_sync_in;
      r_in_win2  <= r_in_win1;
      r_en2      <= r_en1;
      r_col2     <= r_col1;
      h_sync     <= r_hs1;
      v_sync     <= r_vs1;
      // Rises together with v_sync: compares its next value against its current one.
      frame_tick <= r_vs1 & ~v_sync;
    end
  end

  // MSB of each display byte is the leftmost pixel.
  assign w_sel = mem_data[3'd7 - r_col2];

  always_comb begin
    rgb = 12'h000;
    if (!r_en2)          rgb = 12'h000;
    else if (!r_in_win2) rgb = BORDER_COLOR;
    else if (w_sel)      rgb = FG_COLOR;
    else                 rgb = BG_COLOR;
  end

endmodule

// File: tb/tb_chip8_vga_pixel_fetch.sv
// Directed bench for chip8_vga_pixel_fetch with a one-cycle-latency display RAM model.
module tb_chip8_vga_pixel_fetch;

  logic        clk = 1'b0;
  logic        res;
  logic [10:0] h_pos;
  logic [10:0] v_pos;
  logic        pixel_enable;
  logic        h_sync_in;
  logic        v_sync_in;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [11:0] rgb;
  logic        h_sync;
  logic        v_sync;
  logic        frame_tick;

  int errs   = 0;
  int checks = 0;

  logic [7:0] ram [256];

  chip8_vga_pixel_fetch dut (
    .clk          (clk),
    .res          (res),
    .h_pos        (h_pos),
    .v_pos        (v_pos),
    .pixel_enable (pixel_enable),
    .h_sync_in    (h_sync_in),
    .v_sync_in    (v_sync_in),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .rgb          (rgb),
    .h_sync       (h_sync),
    .v_sync       (v_sync),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  initial mem_data = 8'h00;
  always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input logic en);
    h_pos        = 11'(h);
    v_pos        = 11'(v);
    pixel_enable = en;
  endtask

  // Apply hs/vs bit i in cycle i; outputs must replay them two cycles later.
  task automatic run_sync(input logic [31:0] hp, input logic [31:0] vp, input int n);
    logic prev;
    for (int i = 0; i < n; i++) begin
      if (i >= 2) begin
        prev = (i >= 3) ? vp[i-3] : 1'b0;
        chk("h_sync", 32'(h_sync), 32'(hp[i-2]));
        chk("v_sync", 32'(v_sync), 32'(vp[i-2]));
        chk("frame_tick", 32'(frame_tick), 32'(vp[i-2] & ~prev));
      end
      h_sync_in = hp[i];
      v_sync_in = vp[i];
      cyc();
    end
    h_sync_in = 1'b0;
    v_sync_in = 1'b0;
  endtask

  logic [15:0] bits;
  int hs [4];
  int vs [4];

  initial begin
    foreach (ram[i]) ram[i] = 8'h00;
    res = 1'b1; h_sync_in = 1'b0; v_sync_in = 1'b0;
    drive(0, 0, 1'b0);
    #1;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 1'($urandom));
      h_sync_in = 1'($urandom);
      v_sync_in = 1'($urandom);
      cyc();
    end
    chk("rst_rgb", 32'(rgb), 32'h000);
    chk("rst_hsync", 32'(h_sync), 0);
    chk("rst_vsync", 32'(v_sync), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    res = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
    drive(0, 0, 1'b0);
    repeat (3) cyc();

    // Top-left pixel, then the next scaled column in the same byte
    ram[0] = 8'h80;
    drive(64, 112, 1'b1);
    cyc();
    chk("tl_mem_rd", 32'(mem_rd), 1);
    chk("tl_addr", 32'(mem_addr), 32'h00);
    drive(72, 112, 1'b1);
    cyc();
    chk("tl_rgb", 32'(rgb), 32'hFFF);
    drive(0, 0, 1'b0);
    cyc();
    chk("col1_rgb", 32'(rgb), 32'h000);
    cyc();
    chk("blank_rgb", 32'(rgb), 32'h000);

    // Bottom-right pixel
    ram[255] = 8'h01;
    drive(575, 367, 1'b1);
    cyc();
    chk("br_mem_rd", 32'(mem_rd), 1);
    chk("br_addr", 32'(mem_addr), 32'hFF);
    drive(0, 0, 1'b0);
    cyc();
    chk("br_rgb_lit", 32'(rgb), 32'hFFF);
    ram[255] = 8'hFE;
    drive(575, 367, 1'b1);
    cyc();
    drive(0, 0, 1'b0);
    cyc();
    chk("br_rgb_dark", 32'(rgb), 32'h000);

    // Just outside each window edge: border colour, no read, address held
    hs[0] = 63;  vs[0] = 200;
    hs[1] = 576; vs[1] = 200;
    hs[2] = 300; vs[2] = 111;
    hs[3] = 300; vs[3] = 368;
    for (int k = 0; k < 4; k++) begin
      drive(hs[k], vs[k], 1'b1);
      cyc();
      chk("edge_mem_rd", 32'(mem_rd), 0);
      chk("edge_addr", 32'(mem_addr), 32'hFF);
      drive(0, 0, 1'b0);
      cyc();
      chk("edge_rgb", 32'(rgb), 32'h222);
    end

    // Back-to-back scaled pixels across two bytes of row 0: 0xA5 then 0x3C
    ram[0] = 8'hA5;
    ram[1] = 8'h3C;
    bits = 16'b1010_0101_0011_1100;
    for (int i = 0; i < 18; i++) begin
      if (i >= 2) chk("stream_rgb", 32'(rgb), bits[15-(i-2)] ? 32'hFFF : 32'h000);
      if (i < 16) drive(64 + 8*i, 112, 1'b1);
      else        drive(0, 0, 1'b0);
      cyc();
    end

    // Blanking inside window coordinates
    drive(100, 200, 1'b0);
    cyc();
    cyc();
    chk("blank_in_win", 32'(rgb), 32'h000);

    // Sync delay, and vsync held across two lines giving one tick
    run_sync(32'h0000_000E, 32'h0000_0000, 10);
    run_sync(32'h0000_0000, 32'h001F_FFE0, 26);

    // Reset mid-frame with a pixel in flight
    drive(64, 112, 1'b1);
    cyc();
    res = 1'b1;
    cyc();
    chk("midrst_rgb", 32'(rgb), 32'h000);
    chk("midrst_mem_rd", 32'(mem_rd), 0);
    drive(0, 0, 1'b0);
    cyc();
    res = 1'b0;
    run_sync(32'h0000_0000, 32'h0000_0000, 10);
    run_sync(32'h0000_0000, 32'h0000_0FF0, 16);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
